// File: rtl/mag_bus_pkg.sv
// Shared definitions for the MagSimulator bus operand loader.
// Holds bus/operand widths, control and status bit positions, the default
// register addresses, the streamer FSM state type and the status-word packer.
package mag_bus_pkg;

    localparam int unsigned OP_W   = 64;
    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ADDR_W-1:0] CTRL_ADDR_DEF = 10'h200;
    localparam logic [ADDR_W-1:0] STAT_ADDR_DEF = 10'h204;

    // CTRL register bits (byte 0)
    localparam int unsigned CTRL_LAUNCH_BIT = 0;
    localparam int unsigned CTRL_ABORT_BIT  = 1;
    localparam int unsigned CTRL_CLRERR_BIT = 2;

    // STATUS register fields
    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_ERR_BIT  = 1;
    localparam int unsigned STAT_CNT_LSB  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } opState_t;

    // Assemble the read-only status word; unused bits read as zero.
    function automatic logic [BUS_W-1:0] statusWord(
        input logic             busy,
        input logic             err,
        input logic [CNT_W-1:0] cnt
    );
        logic [BUS_W-1:0] w;
        w                         = '0;
        w[STAT_BUSY_BIT]          = busy;
        w[STAT_ERR_BIT]           = err;
        w[STAT_CNT_LSB +: CNT_W]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/mag_op_streamer.sv
// Operand burst streamer: IDLE/SEND FSM that presents each operand slot in
// turn on a valid/ready interface and counts completed bursts.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   launch, abort     - qualified burst start / burst cancel requests
//   fetchIndex_c      - slot the top should present on fetchData (combinational)
//   fetchData         - contents of slot fetchIndex_c
//   opReady           - core accepts the current beat
//   opValid, opData, opIndex, opLast - registered beat outputs
//   busy              - burst in progress
//   burstCount        - completed bursts, wrapping
module mag_op_streamer
    import mag_bus_pkg::*;
#(
    parameter int unsigned N_OPERANDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             launch,
    input  logic             abort,
    input  logic             opReady,
    input  logic [OP_W-1:0]  fetchData,
    output logic [IDX_W-1:0] fetchIndex_c,
    output logic             opValid,
    output logic [OP_W-1:0]  opData,
    output logic [IDX_W-1:0] opIndex,
    output logic             opLast,
    output logic             busy,
    output logic [CNT_W-1:0] burstCount
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPERANDS - 1);

    opState_t         state, stateNext;
    logic             validNext;
    logic [OP_W-1:0]  dataNext;
    logic [IDX_W-1:0] indexNext;
    logic             lastNext;
    logic [CNT_W-1:0] countNext;

    // Slot needed for the next beat: slot 0 on launch, otherwise the successor.
    assign fetchIndex_c = (state == SEND) ? IDX_W'(opIndex + 1'b1) : '0;
    assign busy         = (state == SEND);

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            opValid    <= 1'b0;
            opData     <= '0;
            opIndex    <= '0;
            opLast     <= 1'b0;
            burstCount <= '0;
        end else begin
            state      <= stateNext;
            opValid    <= validNext;
            opData     <= dataNext;
            opIndex    <= indexNext;
            opLast     <= lastNext;
            burstCount <= countNext;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext = state;
        validNext = opValid;
        dataNext  = opData;
        indexNext = opIndex;
        lastNext  = opLast;
        countNext = burstCount;
        case (state)
            IDLE: begin
                if (launch) begin
                    stateNext = SEND;
                    validNext = 1'b1;
                    indexNext = '0;
                    dataNext  = fetchData;
                    lastNext  = (LAST_IDX == '0);
                end
            end
            SEND: begin
                if (abort) begin
                    stateNext = IDLE;
                    validNext = 1'b0;
                    lastNext  = 1'b0;
                end else if (opValid && opReady) begin
                    if (opLast) begin
                        stateNext = IDLE;
                        validNext = 1'b0;
                        lastNext  = 1'b0;
                        countNext = burstCount + 1'b1;
                    end else begin
                        // Snapshot the next slot so opData stays stable while stalled
                        indexNext = fetchIndex_c;
                        dataNext  = fetchData;
                        lastNext  = (fetchIndex_c == LAST_IDX);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                validNext = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mag_bus_operand_loader.sv
// MagSimulator host front end: decodes MCU bus cycles into an array of 64-bit
// operand registers, a CTRL doorbell and a STATUS register, and streams the
// operands to the simulation core on launch.
// Build option: define MAG_OPERAND_READBACK_EN to make operand addresses
// readable; otherwise they read as zero and the operand read mux is absent.
// Ports:
//   BCLK, Reset           - clock, synchronous active-high reset
//   Address, nCS, nRD     - byte address, chip select, read strobe (active low)
//   nWR, DataIn           - per-byte write enables (active low), write data
//   DataOut, DataOE       - registered read data and pad drive enable
//   OpValid/OpReady       - operand handshake to the core
//   OpData, OpIndex, OpLast - operand beat payload
//   Busy                  - burst in progress
module mag_bus_operand_loader
    import mag_bus_pkg::*;
#(
    parameter int unsigned       N_OPERANDS = 4,
    parameter logic [ADDR_W-1:0] CTRL_ADDR  = CTRL_ADDR_DEF,
    parameter logic [ADDR_W-1:0] STAT_ADDR  = STAT_ADDR_DEF
) (
    input  logic              BCLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic              nCS,
    input  logic              nRD,
    input  logic [3:0]        nWR,
    input  logic [BUS_W-1:0]  DataIn,
    output logic [BUS_W-1:0]  DataOut,
    output logic              DataOE,
    output logic              OpValid,
    input  logic              OpReady,
    output logic [OP_W-1:0]   OpData,
    output logic [IDX_W-1:0]  OpIndex,
    output logic              OpLast,
    output logic              Busy
);

    localparam int unsigned       WORD_W  = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] OP_SPAN = ADDR_W'(8 * N_OPERANDS);

    logic [WORD_W-1:0] wordAddr;
    logic [WORD_W-2:0] slotSel;
    logic              halfSel;
    logic              isOp, isCtrl, isStat;
    logic              wrCycle, rdCycle;
    logic              opWrite, ctrlWrite;
    logic              launchReq, abortReq, clrErrReq;
    logic              launchGo, errSet;
    logic              errFlag;
    logic [OP_W-1:0]   opRegs [N_OPERANDS];
    logic [IDX_W-1:0]  fetchIndex;
    logic [OP_W-1:0]   fetchData;
    logic [CNT_W-1:0]  burstCount;
    logic [BUS_W-1:0]  rdMux;
    logic              unusedAddrLsb;

    assign unusedAddrLsb = ^Address[1:0];

    // Address decode
    assign wordAddr = Address[ADDR_W-1:2];
    assign slotSel  = wordAddr[WORD_W-1:1];
    assign halfSel  = wordAddr[0];
    assign isOp     = (Address < OP_SPAN);
    assign isCtrl   = (wordAddr == CTRL_ADDR[ADDR_W-1:2]);
    assign isStat   = (wordAddr == STAT_ADDR[ADDR_W-1:2]);

    assign wrCycle   = !nCS && (nWR != 4'hF);
    assign rdCycle   = !nCS && !nRD;
    assign opWrite   = wrCycle && isOp && !Busy;
    assign ctrlWrite = wrCycle && isCtrl && !nWR[0];
    assign launchReq = ctrlWrite && DataIn[CTRL_LAUNCH_BIT];
    assign abortReq  = ctrlWrite && DataIn[CTRL_ABORT_BIT];
    assign clrErrReq = ctrlWrite && DataIn[CTRL_CLRERR_BIT];

    // Abort overrides a simultaneous launch; a launch during a burst is an error.
    assign launchGo = launchReq && !abortReq && !Busy;
    assign errSet   = (wrCycle && isOp && Busy) || (launchReq && !abortReq && Busy);

    // Operand register array with per-byte write enables
    always_ff @(posedge BCLK) begin
        if (Reset) begin
            for (int i = 0; i < N_OPERANDS; i++) begin
                opRegs[i] <= '0;
            end
        end else if (opWrite) begin
            for (int i = 0; i < N_OPERANDS; i++) begin
                if (slotSel == (WORD_W-1)'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (!nWR[b]) begin
                            if (halfSel) begin
                                opRegs[i][32 + 8*b +: 8] <= DataIn[8*b +: 8];
                            end else begin
                                opRegs[i][8*b +: 8] <= DataIn[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Sticky error flag; a new error in the clearing cycle is kept.
    always_ff @(posedge BCLK) begin
        if (Reset) begin
            errFlag <= 1'b0;
        end else begin
            errFlag <= (errFlag && !clrErrReq) || errSet;
        end
    end

    // Slot fetch for the streamer
    always_comb begin
        fetchData = '0;
        for (int i = 0; i < N_OPERANDS; i++) begin
            if (fetchIndex == IDX_W'(i)) begin
                fetchData = opRegs[i];
            end
        end
    end

`ifdef MAG_OPERAND_READBACK_EN
    logic [BUS_W-1:0] opRdWord;

    // Operand readback mux
    always_comb begin
        opRdWord = '0;
        for (int i = 0; i < N_OPERANDS; i++) begin
            if (slotSel == (WORD_W-1)'(i)) begin
                opRdWord = halfSel ? opRegs[i][OP_W-1:BUS_W] : opRegs[i][BUS_W-1:0];
            end
        end
    end
`endif

    // Read data select; CTRL and unmapped addresses read as zero.
    always_comb begin
        rdMux = '0;
        if (isStat) begin
            rdMux = statusWord(Busy, errFlag, burstCount);
        end
`ifdef MAG_OPERAND_READBACK_EN
        else if (isOp) begin
            rdMux = opRdWord;
        end
`endif
    end

    // Registered read port; samples pre-write contents on a concurrent write.
    always_ff @(posedge BCLK) begin
        if (Reset) begin
            DataOut <= '0;
            DataOE  <= 1'b0;
        end else begin
            DataOE <= rdCycle;
            if (rdCycle) begin
                DataOut <= rdMux;
            end
        end
    end

    mag_op_streamer #(
        .N_OPERANDS (N_OPERANDS)
    ) uStreamer (
        .clk          (BCLK),
        .reset        (Reset),
        .launch       (launchGo),
        .abort        (abortReq),
        .opReady      (OpReady),
        .fetchData    (fetchData),
        .fetchIndex_c (fetchIndex),
        .opValid      (OpValid),
        .opData       (OpData),
        .opIndex      (OpIndex),
        .opLast       (OpLast),
        .busy         (Busy),
        .burstCount   (burstCount)
    );

endmodule

// File: tb/tb_mag_bus_operand_loader.sv
// Scoreboard bench for mag_bus_operand_loader: stimulus pushes expected read
// words and operand beats into queues; a negedge monitor pops and compares.
module tb_mag_bus_operand_loader;

    localparam int unsigned N    = 4;
    localparam logic [9:0]  CTRL = 10'h200;
    localparam logic [9:0]  STAT = 10'h204;

    logic        BCLK    = 1'b0;
    logic        Reset   = 1'b1;
    logic [9:0]  Address = '0;
    logic        nCS     = 1'b1;
    logic        nRD     = 1'b1;
    logic [3:0]  nWR     = 4'hF;
    logic [31:0] DataIn  = '0;
    logic        OpReady = 1'b0;
    logic [31:0] DataOut;
    logic        DataOE;
    logic        OpValid;
    logic [63:0] OpData;
    logic [4:0]  OpIndex;
    logic        OpLast;
    logic        Busy;

    mag_bus_operand_loader #(.N_OPERANDS(N)) dut (
        .BCLK    (BCLK),
        .Reset   (Reset),
        .Address (Address),
        .nCS     (nCS),
        .nRD     (nRD),
        .nWR     (nWR),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .DataOE  (DataOE),
        .OpValid (OpValid),
        .OpReady (OpReady),
        .OpData  (OpData),
        .OpIndex (OpIndex),
        .OpLast  (OpLast),
        .Busy    (Busy)
    );

    always #5 BCLK = ~BCLK;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t       beatQ [$];
    logic [31:0] rdQ [$];
    logic [63:0] model [N];
    beat_t       monBeat;
    logic [31:0] monRd;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rbExp(input logic [31:0] v);
`ifdef MAG_OPERAND_READBACK_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    function automatic logic [31:0] stat(input logic b, input logic e, input logic [7:0] c);
        return {16'h0, c, 6'h0, e, b};
    endfunction

    // Scoreboard monitor
    always @(negedge BCLK) begin
        if (!Reset) begin
            if (DataOE) begin
                if (rdQ.size() == 0) begin
                    check("unexpected read response", 64'(DataOut), 64'hX);
                end else begin
                    monRd = rdQ.pop_front();
                    check("read data", 64'(DataOut), 64'(monRd));
                end
            end
            if (OpValid && OpReady) begin
                if (beatQ.size() == 0) begin
                    check("unexpected beat", 64'(OpIndex), 64'hX);
                end else begin
                    monBeat = beatQ.pop_front();
                    check("beat index", 64'(OpIndex), 64'(monBeat.idx));
                    check("beat data", OpData, monBeat.data);
                    check("beat last", 64'(OpLast), 64'(monBeat.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge BCLK);
        #1;
    endtask

    task automatic busWrite(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be = 4'h0);
        Address = a; DataIn = d; nWR = be; nCS = 1'b0;
        tick();
        nCS = 1'b1; nWR = 4'hF;
    endtask

    task automatic modelWrite(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        int slot;
        int half;
        if (a < 10'(8 * N)) begin
            slot = int'(a >> 3);
            half = int'(a[2]);
            for (int b = 0; b < 4; b++) begin
                if (!be[b]) model[slot][32*half + 8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic opWrite(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be = 4'h0);
        busWrite(a, d, be);
        modelWrite(a, d, be);
    endtask

    task automatic busRead(input logic [9:0] a, input logic [31:0] exp);
        rdQ.push_back(exp);
        Address = a; nCS = 1'b0; nRD = 1'b0;
        tick();
        nCS = 1'b1; nRD = 1'b1;
        tick();
        check("DataOE release", 64'(DataOE), 64'd0);
    endtask

    task automatic pushBurst();
        for (int i = 0; i < N; i++) begin
            beatQ.push_back('{idx: 5'(i), data: model[i], last: (i == N - 1)});
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while (Busy && n < maxCycles) begin
            tick();
            n++;
        end
        check("burst completes in budget", 64'(Busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) model[i] = '0;

        // Reset state
        repeat (10) tick();
        check("reset DataOE", 64'(DataOE), 64'd0);
        check("reset OpValid", 64'(OpValid), 64'd0);
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset OpIndex", 64'(OpIndex), 64'd0);
        check("reset OpLast", 64'(OpLast), 64'd0);
        check("reset DataOut", 64'(DataOut), 64'd0);
        Reset = 1'b0;
        tick();
        busRead(STAT, 32'h0);

        // Basic burst with hand-computed doubles
        opWrite(10'd0,  32'h0000_0000);
        opWrite(10'd4,  32'h3FF0_0000);
        opWrite(10'd8,  32'h0000_0000);
        opWrite(10'd12, 32'h3FF0_0000);
        beatQ.push_back('{idx: 5'd0, data: 64'h3FF0_0000_0000_0000, last: 1'b0});
        beatQ.push_back('{idx: 5'd1, data: 64'h3FF0_0000_0000_0000, last: 1'b0});
        beatQ.push_back('{idx: 5'd2, data: 64'h0, last: 1'b0});
        beatQ.push_back('{idx: 5'd3, data: 64'h0, last: 1'b1});
        OpReady = 1'b1;
        busWrite(CTRL, 32'h1);
        check("busy after launch", 64'(Busy), 64'd1);
        waitIdle(20);
        OpReady = 1'b0;
        busRead(STAT, 32'h0000_0100);

        // Stall: OpData/OpIndex stable, one beat per OpReady pulse
        opWrite(10'd0,  32'h1122_3344);
        opWrite(10'd16, 32'h1111_1111);
        opWrite(10'd20, 32'h2222_2222);
        opWrite(10'd24, 32'h3333_3333);
        opWrite(10'd28, 32'h4444_4444);
        pushBurst();
        busWrite(CTRL, 32'h1);
        for (int c = 0; c < 5; c++) begin
            check("stall OpValid", 64'(OpValid), 64'd1);
            check("stall OpIndex", 64'(OpIndex), 64'd0);
            check("stall OpData", OpData, 64'h3FF0_0000_1122_3344);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            OpReady = 1'b1;
            tick();
            OpReady = 1'b0;
            if (k < 3) check("index after pulse", 64'(OpIndex), 64'(k + 1));
            else       check("idle after last pulse", 64'(Busy), 64'd0);
            tick();
        end
        busRead(STAT, 32'h0000_0200);

        // Byte enables, readback, read-during-write, unmapped space
        opWrite(10'd0, 32'hAABB_CCDD, 4'b1110);
        busRead(10'd0,  rbExp(32'h1122_33DD));
        busRead(10'd4,  rbExp(32'h3FF0_0000));
        busRead(10'd28, rbExp(32'h4444_4444));
        rdQ.push_back(rbExp(32'h3FF0_0000));
        Address = 10'd12; DataIn = 32'h1234_5678; nWR = 4'h0; nRD = 1'b0; nCS = 1'b0;
        tick();
        nCS = 1'b1; nRD = 1'b1; nWR = 4'hF;
        modelWrite(10'd12, 32'h1234_5678, 4'h0);
        tick();
        busRead(10'd12, rbExp(32'h1234_5678));
        busWrite(10'h020, 32'hFFFF_FFFF);
        busRead(10'h020, 32'h0);
        busRead(CTRL, 32'h0);
        busRead(10'h3FC, 32'h0);

        // Writes and relaunch during a burst are dropped and flag an error
        pushBurst();
        busWrite(CTRL, 32'h1);
        busWrite(10'd0, 32'hDEAD_BEEF);
        busWrite(CTRL, 32'h1);
        busRead(STAT, 32'h0000_0203);
        busWrite(CTRL, 32'h4);
        busRead(STAT, 32'h0000_0201);
        check("index unchanged by relaunch", 64'(OpIndex), 64'd0);
        OpReady = 1'b1;
        waitIdle(20);
        OpReady = 1'b0;
        busRead(STAT, 32'h0000_0300);
        busRead(10'd0, rbExp(32'h1122_33DD));

        // Abort at OpIndex 2
        beatQ.push_back('{idx: 5'd0, data: model[0], last: 1'b0});
        beatQ.push_back('{idx: 5'd1, data: model[1], last: 1'b0});
        busWrite(CTRL, 32'h1);
        for (int k = 0; k < 2; k++) begin
            OpReady = 1'b1;
            tick();
            OpReady = 1'b0;
            tick();
        end
        check("pre-abort OpIndex", 64'(OpIndex), 64'd2);
        check("pre-abort OpValid", 64'(OpValid), 64'd1);
        busWrite(CTRL, 32'h2);
        check("abort OpValid", 64'(OpValid), 64'd0);
        check("abort Busy", 64'(Busy), 64'd0);
        busRead(STAT, 32'h0000_0300);

        // Abort and launch together: no burst
        busWrite(CTRL, 32'h3);
        check("abort beats launch", 64'(Busy), 64'd0);

        // Back-to-back bursts
        OpReady = 1'b1;
        pushBurst();
        pushBurst();
        busWrite(CTRL, 32'h1);
        waitIdle(20);
        busWrite(CTRL, 32'h1);
        check("back-to-back launch", 64'(Busy), 64'd1);
        waitIdle(20);
        OpReady = 1'b0;
        busRead(STAT, 32'h0000_0500);

        // Burst counter wrap 255 -> 0
        OpReady = 1'b1;
        for (int k = 0; k < 250; k++) begin
            pushBurst();
            busWrite(CTRL, 32'h1);
            waitIdle(20);
        end
        OpReady = 1'b0;
        busRead(STAT, 32'h0000_FF00);
        OpReady = 1'b1;
        pushBurst();
        busWrite(CTRL, 32'h1);
        waitIdle(20);
        OpReady = 1'b0;
        busRead(STAT, 32'h0000_0000);

        // Reset mid-burst
        busWrite(CTRL, 32'h1);
        check("mid-burst OpValid", 64'(OpValid), 64'd1);
        Reset = 1'b1;
        tick();
        check("mid-reset OpValid", 64'(OpValid), 64'd0);
        check("mid-reset Busy", 64'(Busy), 64'd0);
        check("mid-reset OpIndex", 64'(OpIndex), 64'd0);
        check("mid-reset OpLast", 64'(OpLast), 64'd0);
        check("mid-reset DataOE", 64'(DataOE), 64'd0);
        check("mid-reset DataOut", 64'(DataOut), 64'd0);
        Reset = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        tick();
        busRead(STAT, 32'h0);
        busRead(10'd4, rbExp(32'h0));

        repeat (3) tick();
        check("beat queue drained", 64'(beatQ.size()), 64'd0);
        check("read queue drained", 64'(rdQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mag_bus_operand_loader.md
Name: mag_bus_operand_loader

Overview:
- Host-facing front end of MagSimulator; sits between the external MCU bus (BCLK domain) and the simulation core.
- Captures 32-bit bus writes into an array of 64-bit IEEE-754 double operand registers; low word at the even word address, high word at the odd word address.
- On a doorbell write, streams all operands to the core over a valid/ready interface.
- Provides status and optional operand readback.

Parameters:
- N_OPERANDS, 4, number of 64-bit operand slots (1..32); occupies byte addresses 0 .. 8*N_OPERANDS-1.
- CTRL_ADDR, 10'h200, byte address of the control/doorbell register.
- STAT_ADDR, 10'h204, byte address of the read-only status register.

Ports:
- BCLK  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Address  in  10  byte address; bits [1:0] ignored.
- nCS  in  1  chip select, active low.
- nRD  in  1  read strobe, active low.
- nWR  in  4  per-byte write enables, active low; nWR[i] covers DataIn[8i+7:8i].
- DataIn  in  32  write data.
- DataOut  out  32  registered read data.
- DataOE  out  1  registered: drive Data pads.
- OpValid  out  1  operand valid to core.
- OpReady  in  1  core accepts operand.
- OpData  out  64  operand value {high word, low word}.
- OpIndex  out  5  slot index of OpData.
- OpLast  out  1  marks final operand of the burst.
- Busy  out  1  burst in progress.

Behaviour:
- Reset values: all operand regs 0, DataOut 0, DataOE 0, OpValid 0, OpIndex 0, OpLast 0, Busy 0, error flag 0, burst counter 0, FSM IDLE.
- Write cycle: any BCLK edge with nCS=0 and nWR!=4'hF. Writes are level-based and idempotent; a strobe held for several cycles rewrites the same value.
- Operand write, address < 8*N_OPERANDS:
  - Word w = Address[9:2]; slot = w>>1; half = w[0] (0 = low word).
  - Only the enabled bytes update.
- Operand writes while Busy: dropped; sticky error flag set.
- Addresses that are unmapped: writes ignored, reads return 0.
- CTRL write, byte 0 enabled:
  - bit0 = launch; bit1 = abort; bit2 = clear error.
  - Launch while Busy: ignored and sets the error flag.
  - Abort in the same cycle as launch: abort wins.
- Reads (nCS=0, nRD=0):
  - DataOut and DataOE update one cycle later (latency 1); DataOE falls one cycle after the strobe ends.
  - Simultaneous read and write to the same address returns the pre-write value.
- STATUS word: [0] Busy, [1] error, [15:8] burst counter (completed bursts, wraps 255 -> 0), others 0.
- FSM, IDLE -> SEND:
  - On launch: OpIndex <= 0, OpValid <= 1 on the next edge.
- FSM, SEND:
  - OpData reflects the slot at OpIndex, snapshotted when the beat is presented; it is stable while OpValid=1 and OpReady=0.
  - OpLast = (OpIndex == N_OPERANDS-1).
  - On OpValid & OpReady with OpLast=0: OpIndex increments.
  - On OpValid & OpReady with OpLast=1: return to IDLE, OpValid <= 0, burst counter +1.
- Abort during SEND: next edge OpValid 0, IDLE, counter unchanged.
- Busy = (state == SEND).
- Back-to-back: a launch is accepted the cycle after returning to IDLE.
- OpValid never drops without a handshake except on abort or Reset.
- Reset mid-burst: immediate return to the reset values listed above.

Optional Feature:
- MAG_OPERAND_READBACK_EN
  - Defined: reads of operand addresses return the stored word.
  - Undefined: operand-address reads return 32'h0; the operand read mux is removed. STATUS and CTRL reads are unaffected; CTRL always reads 0.

Decomposition:
- Package mag_bus_pkg: CTRL/STAT bit positions, default addresses, FSM state typedef {IDLE, SEND}, operand width constant 64.
- One natural sub-module, mag_op_streamer: the IDLE/SEND FSM, index counter and output register.
- Bus decode and the register array stay in the top.

Test Plan:
1. Reset held 10 cycles -> DataOE=0, OpValid=0, Busy=0, STATUS read returns 32'h0.
2. Write 0x0000_0000 @0, 0x3FF0_0000 @4, 0 @8, 0x3FF0_0000 @12, then CTRL=1 with OpReady=1 -> 4 beats; slots 0,1 = 64'h3FF0_0000_0000_0000; OpLast on OpIndex 3; STATUS[15:8]=1.
3. Launch with OpReady held 0 for 5 cycles -> OpValid=1 and OpData/OpIndex stable; one beat per OpReady pulse.
4. nWR=4'b1110, DataIn=0xAABBCCDD @0 over prior 0x11223344 -> word 0x112233DD; readback (feature on) gives 0x112233DD one cycle after nRD low, 0 with feature off.
5. Write @0 and launch again during a burst -> both ignored; STATUS[1]=1; CTRL=4 clears it.
6. CTRL=2 mid-burst at OpIndex 2 -> OpValid 0 next cycle, counter unchanged; Reset asserted mid-burst -> all outputs at reset values.
